mem_resp_stage: RTL and testbench
=================================

// Module: mem_resp_stage
// PURPOSE
//  Parametrised MEM pipeline stage for a data bus with a split request/response
//  handshake. Loads are issued upstream in EX; data returns here on data_ok.
//  Holds one instruction and stalls until load data arrives. Buffers data_ok
//  when WB back-pressures. Drops responses owned by instructions killed by
//  wb_ex. Sits between EX and WB; forwards dest/result to ID.
// PARAMETERS
//  DATA_W    32  bus/GPR data width, 32 or 64; 64 enables dword loads
//  MAX_OUTST 2   max load responses outstanding on the bus; sizes the discard counter
//  CNT_W     $clog2(MAX_OUTST+1)  discard counter width (derived)
// PORTS
//  clk            in   1       clock
//  reset          in   1       synchronous, active-high
//  wb_ex          in   1       flush from WB: exception/ertn
//  ex_inflight    in   1       EX holds a load whose request was accepted (addr_ok) but not yet forwarded
//  ex_valid       in   1       EX->MEM valid
//  mem_allow_in   out  1       MEM can accept from EX
//  in_pc          in   32      instruction PC
//  in_result      in   DATA_W  ALU result / load address
//  in_ld          in   1       instruction is a load with request issued
//  in_ld_size     in   2       0=byte 1=half 2=word 3=dword
//  in_ld_signed   in   1       sign-extend the load result
//  in_dest        in   5       destination GPR
//  in_gr_we       in   1       GPR write enable
//  in_ex_sys      in   1       syscall exception tag
//  data_ok        in   1       1-cycle pulse: read data valid; in-order w.r.t. requests
//  rdata          in   DATA_W  read data
//  wb_allow_in    in   1       WB can accept
//  out_valid      out  1       MEM->WB valid
//  out_pc         out  32      pass-through
//  out_dest       out  5       pass-through
//  out_result     out  DATA_W  final result (aligned load data or ALU result)
//  out_gr_we      out  1       pass-through
//  out_ex_sys     out  1       pass-through
//  fwd_dest       out  5       in_dest if valid & gr_we, else 0
//  fwd_data       out  DATA_W  out_result
//  fwd_busy       out  1       1 while the held load waits for data; ID must stall on a dest match
// BEHAVIOUR
//  Reset: state IDLE; out_valid=0; mem_allow_in=1; fwd_dest=0; fwd_busy=0; disc_cnt=0; buffers cleared.
//  States: IDLE (empty); WAIT (load, no data yet); DONE (result ready).
//   IDLE->WAIT: accept with in_ld=1.  IDLE->DONE: accept with in_ld=0.
//   WAIT->DONE: data_ok taken while disc_cnt==0; rdata latched into data_buf.
//   DONE->IDLE/WAIT/DONE: on out_valid & wb_allow_in, per the next accepted instr.
//   Any state->IDLE: on wb_ex; wb_ex beats every other event in the same cycle.
//  mem_allow_in = IDLE | (DONE & wb_allow_in); out_valid = DONE.
//  Latency: non-load => out_valid the cycle after acceptance. Load => out_valid
//   the cycle after its data_ok. Data is always served from data_buf; no combinational rdata->out path.
//  Load align: lane = in_result[$clog2(DATA_W/8)-1:0]; select byte/half/word/dword at
//   lane*8; zero- or sign-extend to DATA_W. Alignment is guaranteed upstream (ALE).
//   size 3 with DATA_W==32 is illegal; assertion.
//  Discard counter, updated every cycle:
//   kill_mem = wb_ex & WAIT;  kill_ex = wb_ex & ex_inflight;
//   consume  = data_ok & (disc_cnt!=0 | kill_mem)
//   disc_cnt_n = disc_cnt + kill_mem + kill_ex - consume
//   While disc_cnt!=0, every data_ok is dropped; WAIT does not capture it.
//   data_ok on the wb_ex cycle while WAIT and disc_cnt==0 is dropped, and kill_mem is not
//   counted (the net change is zero). Assertions: disc_cnt never exceeds MAX_OUTST;
//   no data_ok while IDLE|DONE with disc_cnt==0.
//  A load accepted while disc_cnt!=0 stays in WAIT until the stale responses drain.
//  Forward: fwd_busy = WAIT; fwd_dest is zeroed when !valid or !gr_we.
//  Pass-through fields are registered on accept; held stable while stalled.
// STRUCTURE
//  constants.h: LD_SIZE_B/H/W/D encodings; MEM_ST_IDLE/WAIT/DONE; bundle widths when packing.
//  Sub-module: load_align (combinational lane select + extend, DATA_W parametrised).
// TESTING
//  1 ALU op: result=0x1234, wb_allow_in=1 -> out_valid next cycle, out_result=0x1234, fwd_busy=0.
//  2 ld.b signed @addr 0x3, data_ok with rdata=0x80FF_FFFF 2 cycles later -> out_result=0xFFFF_FF80 the cycle after.
//  3 ld.hu @0x2, data_ok while wb_allow_in=0 for 3 cycles -> out_result=0x0000_80FF held stable; accepted when wb_allow_in=1.
//  4 WAIT + ex_inflight=1 + wb_ex -> disc_cnt=2; next 2 data_ok dropped; new load's data_ok (3rd) captured.
//  5 wb_ex coincident with data_ok while WAIT, disc_cnt=0 -> IDLE, disc_cnt stays 0, out_valid never rises.
//  6 DATA_W=64 ld.d @0x0, rdata=0x0123_4567_89AB_CDEF -> out_result identical; ld.w signed @0x4 -> 0x0000_0000_0123_4567.

Source files
------------

// File: rtl/mem_resp_stage_pkg.sv
// rtl/mem_resp_stage_pkg.sv - shared encodings for the MEM response stage
// Contents: load size encodings, MEM stage state enum.
package mem_resp_stage_pkg;

    localparam logic [1:0] LD_SIZE_B = 2'd0;
    localparam logic [1:0] LD_SIZE_H = 2'd1;
    localparam logic [1:0] LD_SIZE_W = 2'd2;
    localparam logic [1:0] LD_SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        MEM_ST_IDLE = 2'd0,
        MEM_ST_WAIT = 2'd1,
        MEM_ST_DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_resp_stage_load_align.sv
// rtl/mem_resp_stage_load_align.sv - load data lane select and zero/sign extension
// Ports:
//   data   in  DATA_W  raw bus word
//   lane   in  LANE_W  byte offset of the access within the bus word
//   size   in  2       0=byte 1=half 2=word 3=dword
//   sgn    in  1       sign-extend when set, zero-extend otherwise
//   result out DATA_W  aligned, extended load value
module load_align
    import mem_resp_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [LANE_W-1:0] lane,
    input  logic [1:0]        size,
    input  logic              sgn,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted = data >> {lane, 3'b000};
        // dword (and anything full-width) passes straight through
        result  = shifted;
        unique case (size)
            LD_SIZE_B: result = sgn ? DATA_W'($signed(shifted[7:0]))  : DATA_W'(shifted[7:0]);
            LD_SIZE_H: result = sgn ? DATA_W'($signed(shifted[15:0])) : DATA_W'(shifted[15:0]);
            LD_SIZE_W: result = sgn ? DATA_W'($signed(shifted[31:0])) : DATA_W'(shifted[31:0]);
            default:   result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_resp_stage.sv
// rtl/mem_resp_stage.sv - MEM pipeline stage with split request/response load handling
// Ports:
//   clk, reset (sync, active-high)
//   wb_ex, ex_inflight                      flush and EX outstanding-load indication
//   ex_valid/mem_allow_in, in_*             instruction from EX
//   data_ok, rdata                          load response from the data bus
//   out_valid/wb_allow_in, out_*            instruction to WB
//   fwd_dest, fwd_data, fwd_busy            bypass to ID
module mem_resp_stage
    import mem_resp_stage_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 2,
    parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_ex,
    input  logic              ex_inflight,
    input  logic              ex_valid,
    output logic              mem_allow_in,
    input  logic [31:0]       in_pc,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_ld,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_signed,
    input  logic [4:0]        in_dest,
    input  logic              in_gr_we,
    input  logic              in_ex_sys,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata,
    input  logic              wb_allow_in,
    output logic              out_valid,
    output logic [31:0]       out_pc,
    output logic [4:0]        out_dest,
    output logic [DATA_W-1:0] out_result,
    output logic              out_gr_we,
    output logic              out_ex_sys,
    output logic [4:0]        fwd_dest,
    output logic [DATA_W-1:0] fwd_data,
    output logic              fwd_busy
);

    localparam int LANE_W = $clog2(DATA_W / 8);

    mem_state_t        state, state_n;
    logic [CNT_W-1:0]  disc_cnt;
    logic [DATA_W-1:0] result_r, data_buf, aligned;
    logic              ld_r, ld_signed_r;
    logic [1:0]        ld_size_r;

    logic accept, capture, kill_mem, kill_ex, consume;

    always_comb begin
        state_n      = state;
        mem_allow_in = 1'b0;
        out_valid    = 1'b0;
        fwd_busy     = 1'b0;
        case (state)
            MEM_ST_IDLE: begin
                mem_allow_in = 1'b1;
                if (ex_valid) state_n = in_ld ? MEM_ST_WAIT : MEM_ST_DONE;
            end
            MEM_ST_WAIT: begin
                fwd_busy = 1'b1;
                if (capture) state_n = MEM_ST_DONE;
            end
            MEM_ST_DONE: begin
                out_valid    = 1'b1;
                mem_allow_in = wb_allow_in;
                if (wb_allow_in) begin
                    if (ex_valid) state_n = in_ld ? MEM_ST_WAIT : MEM_ST_DONE;
                    else          state_n = MEM_ST_IDLE;
                end
            end
            default: state_n = MEM_ST_IDLE;
        endcase
        if (wb_ex) state_n = MEM_ST_IDLE;
    end

    assign accept   = ex_valid & mem_allow_in & ~wb_ex;
    assign kill_mem = wb_ex & (state == MEM_ST_WAIT);
    assign kill_ex  = wb_ex & ex_inflight;
    // A response arriving on the flush cycle belongs to the killed WAIT load;
    // it is consumed here instead of being counted, so the net change is zero.
    assign consume  = data_ok & ((disc_cnt != '0) | kill_mem);
    // Stale responses are always older than the held load, so it only
    // captures once the discard counter has drained.
    assign capture  = (state == MEM_ST_WAIT) & data_ok & (disc_cnt == '0) & ~wb_ex;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= MEM_ST_IDLE;
            disc_cnt    <= '0;
            out_pc      <= '0;
            out_dest    <= '0;
            out_gr_we   <= 1'b0;
            out_ex_sys  <= 1'b0;
            result_r    <= '0;
            ld_r        <= 1'b0;
            ld_size_r   <= '0;
            ld_signed_r <= 1'b0;
            data_buf    <= '0;
        end else begin
            state    <= state_n;
            disc_cnt <= disc_cnt + CNT_W'(kill_mem) + CNT_W'(kill_ex) - CNT_W'(consume);
            if (accept) begin
                out_pc      <= in_pc;
                out_dest    <= in_dest;
                out_gr_we   <= in_gr_we;
                out_ex_sys  <= in_ex_sys;
                result_r    <= in_result;
                ld_r        <= in_ld;
                ld_size_r   <= in_ld_size;
                ld_signed_r <= in_ld_signed;
            end
            if (capture) data_buf <= rdata;
        end
    end

    // Alignment runs on the registered buffer, keeping rdata off the output path.
    load_align #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_load_align (
        .data   (data_buf),
        .lane   (result_r[LANE_W-1:0]),
        .size   (ld_size_r),
        .sgn    (ld_signed_r),
        .result (aligned)
    );

    assign out_result = ld_r ? aligned : result_r;
    assign fwd_data   = out_result;
    assign fwd_dest   = ((state != MEM_ST_IDLE) && out_gr_we) ? out_dest : 5'd0;

    assert property (@(posedge clk) disable iff (reset) disc_cnt <= CNT_W'(MAX_OUTST));
    assert property (@(posedge clk) disable iff (reset)
        !(data_ok && (state != MEM_ST_WAIT) && (disc_cnt == '0)));
    assert property (@(posedge clk) disable iff (reset)
        !(accept && in_ld && (in_ld_size == LD_SIZE_D) && (DATA_W == 32)));

endmodule

// File: tb/tb_mem_resp_stage.sv
// tb/tb_mem_resp_stage.sv - scoreboard bench for mem_resp_stage with a 64-bit bus
module tb_mem_resp_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_ex, ex_inflight, ex_valid, mem_allow_in;
    logic [31:0] in_pc;
    logic [63:0] in_result;
    logic        in_ld;
    logic [1:0]  in_ld_size;
    logic        in_ld_signed;
    logic [4:0]  in_dest;
    logic        in_gr_we, in_ex_sys;
    logic        data_ok;
    logic [63:0] rdata;
    logic        wb_allow_in, out_valid;
    logic [31:0] out_pc;
    logic [4:0]  out_dest;
    logic [63:0] out_result;
    logic        out_gr_we, out_ex_sys;
    logic [4:0]  fwd_dest;
    logic [63:0] fwd_data;
    logic        fwd_busy;

    mem_resp_stage #(.DATA_W(64), .MAX_OUTST(2)) dut (
        .clk(clk), .reset(reset), .wb_ex(wb_ex), .ex_inflight(ex_inflight),
        .ex_valid(ex_valid), .mem_allow_in(mem_allow_in), .in_pc(in_pc),
        .in_result(in_result), .in_ld(in_ld), .in_ld_size(in_ld_size),
        .in_ld_signed(in_ld_signed), .in_dest(in_dest), .in_gr_we(in_gr_we),
        .in_ex_sys(in_ex_sys), .data_ok(data_ok), .rdata(rdata),
        .wb_allow_in(wb_allow_in), .out_valid(out_valid), .out_pc(out_pc),
        .out_dest(out_dest), .out_result(out_result), .out_gr_we(out_gr_we),
        .out_ex_sys(out_ex_sys), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
        .fwd_busy(fwd_busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] data; bit stale; bit owned; } bus_t;
    typedef struct { logic [31:0] pc; logic [4:0] dest; logic [63:0] result; bit gr_we; bit ex_sys; } exp_t;

    bus_t bus_q[$];
    exp_t exp_q[$];
    exp_t ex_exp;
    int   n_pass = 0;
    int   n_chk  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] ref_align(logic [63:0] d, int lane, int size, bit sgn);
        logic [63:0] v, mask;
        int nb;
        nb   = 8 << size;
        v    = d >> (lane * 8);
        mask = (nb == 64) ? '1 : ((64'd1 << nb) - 64'd1);
        v    = v & mask;
        if (sgn && nb < 64 && v[nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit model_busy();
        foreach (bus_q[i]) if (bus_q[i].owned && !bus_q[i].stale) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit can_give();
        return bus_q.size() > 0 && (bus_q[0].stale || bus_q[0].owned);
    endfunction

    task automatic issue_ex(input bit ld, input logic [1:0] size, input bit sgn,
                            input logic [63:0] res, input logic [63:0] data);
        ex_valid     = 1'b1;
        in_ld        = ld;
        in_ld_size   = size;
        in_ld_signed = sgn;
        in_result    = res;
        in_pc        = $urandom;
        in_dest      = 5'($urandom);
        in_gr_we     = 1'($urandom);
        in_ex_sys    = 1'($urandom);
        ex_inflight  = ld;
        ex_exp.pc     = in_pc;
        ex_exp.dest   = in_dest;
        ex_exp.result = ld ? ref_align(data, int'(res[2:0]), int'(size), sgn) : res;
        ex_exp.gr_we  = in_gr_we;
        ex_exp.ex_sys = in_ex_sys;
        if (ld) bus_q.push_back('{data: data, stale: 1'b0, owned: 1'b0});
    endtask

    task automatic give_data();
        data_ok = 1'b1;
        rdata   = bus_q[0].stale ? {$urandom, $urandom} : bus_q[0].data;
    endtask

    // One clock: cycle-level checks against the model, model bookkeeping, edge.
    task automatic tick();
        bit fire, flush;
        @(negedge clk);
        chk("fwd_busy", fwd_busy, 64'(model_busy()));
        chk("out_valid", out_valid, 64'(exp_q.size() != 0 && !model_busy()));
        chk("mem_allow_in", mem_allow_in, 64'(exp_q.size() == 0 || (!model_busy() && wb_allow_in)));
        fire  = ex_valid && mem_allow_in && !wb_ex;
        flush = wb_ex;
        if (flush) begin
            exp_q.delete();
            foreach (bus_q[i]) bus_q[i].stale = 1'b1;
        end
        if (data_ok) begin
            if (bus_q.size() == 0) chk("bench_bus_empty", 64'd1, 64'd0);
            else void'(bus_q.pop_front());
        end
        if (fire) begin
            exp_q.push_back(ex_exp);
            if (in_ld) bus_q[bus_q.size()-1].owned = 1'b1;
        end
        @(posedge clk);
        #1;
        data_ok = 1'b0;
        wb_ex   = 1'b0;
        if (fire || flush) begin
            ex_valid    = 1'b0;
            in_ld       = 1'b0;
            ex_inflight = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!reset && out_valid && wb_allow_in) begin
            if (exp_q.size() == 0) chk("retire_unexpected", 64'd1, 64'd0);
            else begin
                e = exp_q.pop_front();
                chk("out_pc", out_pc, 64'(e.pc));
                chk("out_dest", out_dest, 64'(e.dest));
                chk("out_result", out_result, e.result);
                chk("out_gr_we", out_gr_we, 64'(e.gr_we));
                chk("out_ex_sys", out_ex_sys, 64'(e.ex_sys));
                chk("fwd_data", fwd_data, e.result);
                chk("fwd_dest", fwd_dest, e.gr_we ? 64'(e.dest) : 64'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] r;
        logic [1:0]  sz;
        int          ln;
        reset = 1'b1; wb_ex = 0; ex_inflight = 0; ex_valid = 0; in_pc = 0; in_result = 0;
        in_ld = 0; in_ld_size = 0; in_ld_signed = 0; in_dest = 0; in_gr_we = 0; in_ex_sys = 0;
        data_ok = 0; rdata = 0; wb_allow_in = 1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_out_valid", out_valid, 64'd0);
        chk("rst_mem_allow_in", mem_allow_in, 64'd1);
        chk("rst_fwd_dest", fwd_dest, 64'd0);
        chk("rst_fwd_busy", fwd_busy, 64'd0);

        // ALU op: visible the cycle after acceptance
        issue_ex(0, 2'd0, 0, 64'h1234, 64'h0);
        tick();
        chk("t1_valid", out_valid, 64'd1);
        chk("t1_result", out_result, 64'h1234);
        chk("t1_busy", fwd_busy, 64'd0);
        tick();

        // ld.b signed at byte 3
        issue_ex(1, 2'd0, 1, 64'h3, 64'h0000_0000_80FF_FFFF);
        tick(); tick();
        give_data(); tick();
        chk("t2_valid", out_valid, 64'd1);
        chk("t2_result", out_result, 64'hFFFF_FFFF_FFFF_FF80);
        tick();

        // ld.hu at byte 2 while WB stalls
        wb_allow_in = 0;
        issue_ex(1, 2'd1, 0, 64'h2, 64'h0000_0000_80FF_FFFF);
        tick();
        give_data(); tick();
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_valid", out_valid, 64'd1);
            chk("t3_hold_result", out_result, 64'h80FF);
            tick();
        end
        wb_allow_in = 1;
        tick();

        // flush with one load in MEM and one in EX: two stale responses
        issue_ex(1, 2'd2, 0, 64'h10, 64'hAAAA_AAAA_AAAA_AAAA);
        tick();
        issue_ex(1, 2'd2, 0, 64'h20, 64'hBBBB_BBBB_BBBB_BBBB);
        tick();
        wb_allow_in = 0; wb_ex = 1;
        tick();
        chk("t4_flush_valid", out_valid, 64'd0);
        chk("t4_flush_busy", fwd_busy, 64'd0);
        wb_allow_in = 1;
        issue_ex(1, 2'd3, 0, 64'h0, 64'hC0C1_C2C3_C4C5_C6C7);
        give_data(); tick();
        give_data(); tick();
        chk("t4_still_wait", fwd_busy, 64'd1);
        give_data(); tick();
        chk("t4_valid", out_valid, 64'd1);
        chk("t4_result", out_result, 64'hC0C1_C2C3_C4C5_C6C7);
        tick();

        // flush coincident with the WAIT load's own response
        issue_ex(1, 2'd2, 0, 64'h0, 64'h1111_2222_3333_4444);
        tick();
        wb_allow_in = 0; wb_ex = 1; give_data();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t5_no_valid", out_valid, 64'd0);
            tick();
        end
        wb_allow_in = 1;
        issue_ex(1, 2'd0, 0, 64'h5, 64'h0000_AB00_0000_0000);
        tick();
        give_data(); tick();
        chk("t5_next_result", out_result, 64'hAB);
        tick();

        // dword and upper-word loads
        issue_ex(1, 2'd3, 0, 64'h0, 64'h0123_4567_89AB_CDEF);
        tick();
        give_data(); tick();
        chk("t6_ld_d", out_result, 64'h0123_4567_89AB_CDEF);
        issue_ex(1, 2'd2, 1, 64'h4, 64'h0123_4567_89AB_CDEF);
        tick();
        give_data(); tick();
        chk("t6_ld_w", out_result, 64'h0000_0000_0123_4567);
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!ex_valid && $urandom_range(0, 3) != 0) begin
                if (bus_q.size() < 2 && $urandom_range(0, 1) == 1) begin
                    sz = 2'($urandom_range(0, 3));
                    ln = ($urandom_range(0, 7) >> sz) << sz;
                    r  = {$urandom, $urandom};
                    r[2:0] = 3'(ln);
                    issue_ex(1, sz, 1'($urandom_range(0, 1)), r, {$urandom, $urandom});
                end else begin
                    issue_ex(0, 2'($urandom_range(0, 3)), 0, {$urandom, $urandom}, 64'h0);
                end
            end
            if (can_give() && $urandom_range(0, 2) == 0) give_data();
            if ($urandom_range(0, 24) == 0) begin
                wb_ex = 1; wb_allow_in = 0;
            end else begin
                wb_allow_in = ($urandom_range(0, 3) != 0);
            end
            tick();
        end

        // drain
        for (int i = 0; i < 300 && (exp_q.size() != 0 || bus_q.size() != 0 || ex_valid); i++) begin
            wb_allow_in = 1;
            if (can_give()) give_data();
            tick();
        end
        chk("drain_scoreboard", 64'(exp_q.size()), 64'd0);
        chk("drain_bus", 64'(bus_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
